serial_add_8b: RTL and testbench

SERIAL_ADD_8B -- requirements
Module: serial_add_8b

---
 rtl/alu_pkg.sv | 13 +
 rtl/full_add.sv | 13 +
 rtl/serial_add_8b.sv | 140 ++++++++++++++
 tb/tb_serial_add_8b.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU blocks: the default operand width
// and the IDLE/SHIFT/DONE state encoding used by the adder and subtractor.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/full_add.sv
// Single-bit full adder used as the per-cycle datapath of the serial adder.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_8b.sv
// Bit-serial adder: accepts a, b, cin, produces one sum bit per cycle LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_8b
    import alu_pkg::*;
#(
    parameter int BIT = ALU_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BIT-1:0] a,
    input  logic [BIT-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BIT-1:0] sum,
    output logic           carry,
`ifdef SERIAL_ADD_OVF_EN
    output logic           ovf,
`endif
    output logic           busy
);

    localparam int            CW   = $clog2(BIT);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);

    alu_state_e     state_q, state_d;
    logic [BIT-1:0] a_q, a_d;
    logic [BIT-1:0] b_q, b_d;
    logic [BIT-1:0] sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           c_q, c_d;
    logic           carry_q, carry_d;
    logic           fa_s;
    logic           fa_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    // Operands are shifted right each cycle so the current bit is always bit 0.
    full_add u_full_add (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB; after BIT shifts bit 0 is in place.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_cout;
                sum_d = {fa_s, sum_q[BIT-1:1]};
                if (cnt_q == LAST) begin
                    carry_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = c_q ^ fa_cout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign sum       = sum_q;
    assign carry     = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_8b.sv
// Self-checking bench for serial_add_8b: directed corner cases plus random
// operands compared against plain integer arithmetic.
module tb_serial_add_8b;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_vectors;
    int n_miscompares;

    serial_add_8b #(.BIT(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, carry, sum} from integer arithmetic.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int u;
        int s;
        logic ov;
        u  = int'(x) + int'(y) + int'(ci);
        s  = int'($signed(x)) + int'($signed(y)) + int'(ci);
        ov = (s > 127) || (s < -128);
        return {ov, u[8:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
        end
    endtask

    task automatic check_result(input string tag, input logic [9:0] e);
        check_eq({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
        check_eq({tag, "_carry"}, 32'(carry), 32'(e[8]));
`ifdef SERIAL_ADD_OVF_EN
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(e[9]));
`endif
    endtask

    // Full transaction: accept, scramble inputs, wait, hold, release.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input int hold);
        logic [9:0] e;
        int lat;
        e = ref_add(ta, tb_v, tc);
        wait_idle();
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        wait_result(lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'd8);
        check_result(tag, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_result({tag, "_hold"}, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_back_idle"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_result({tag, "_after"}, e);
    endtask

    initial begin
        logic [9:0] e1;
        logic [9:0] e2;
        int lat;
        n_vectors = 0;
        n_miscompares = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_result("rst", 10'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_op("d5a3c", 8'h5A, 8'h3C, 1'b0, 0);
        do_op("dff01", 8'hFF, 8'h01, 1'b0, 1);
        do_op("d7f01", 8'h7F, 8'h01, 1'b0, 0);
        do_op("dffff", 8'hFF, 8'hFF, 1'b1, 5);

        // in_valid stays high through SHIFT/DONE with a second operand set.
        e1 = ref_add(8'h12, 8'h34, 1'b1);
        e2 = ref_add(8'hA5, 8'h6C, 1'b0);
        wait_idle();
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = 8'hA5; b = 8'h6C; cin = 1'b0;
        wait_result(lat);
        a = 8'hA5; b = 8'h6C; cin = 1'b0;
        check_eq("bp_latency", 32'(lat), 32'd8);
        check_result("bp_first", e1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_idle", 32'(in_ready), 32'd1);
        check_eq("bp_not_busy", 32'(busy), 32'd0);
        check_result("bp_first_kept", e1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_second_accept", 32'(busy), 32'd1);
        wait_result(lat);
        check_eq("bp_second_latency", 32'(lat), 32'd8);
        check_result("bp_second", e2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset asserted in the middle of SHIFT.
        wait_idle();
        a = 8'hC3; b = 8'h5E; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_result("mrst", 10'd0);
        tick();
        rst_n = 1'b1;
        do_op("post_rst", 8'h01, 8'h02, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
